// File: rtl/alu_issue_ctrl_if.sv
// Issue, ALU drive/return and write-back signal bundle for alu_issue_ctrl.
// The master side is the controller; the slave side is the decode stage, ALU and register file.
interface alu_issue_ctrl_if;
  logic        issue_valid;
  logic        issue_ready;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic [4:0]  rd_idx;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [3:0]  ALU_control;
  logic [31:0] ALU_op_1;
  logic [31:0] ALU_op_2;
  logic [31:0] ALU_result;
  logic [7:0]  ALU_status;
  logic        wb_valid;
  logic        wb_we;
  logic [4:0]  wb_idx;
  logic [31:0] wb_data;
  logic        wb_zero;
  logic        exc_valid;
  logic [1:0]  exc_cause;
  logic        sticky_clr;
  logic [7:0]  sticky_status;

  modport master (
    input  issue_valid, opcode, funct, imm, rd_idx, rs_val, rt_val,
    input  ALU_result, ALU_status, sticky_clr,
    output issue_ready, ALU_control, ALU_op_1, ALU_op_2,
    output wb_valid, wb_we, wb_idx, wb_data, wb_zero, exc_valid, exc_cause, sticky_status
  );

  modport slave (
    output issue_valid, opcode, funct, imm, rd_idx, rs_val, rt_val,
    output ALU_result, ALU_status, sticky_clr,
    input  issue_ready, ALU_control, ALU_op_1, ALU_op_2,
    input  wb_valid, wb_we, wb_idx, wb_data, wb_zero, exc_valid, exc_cause, sticky_status
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Three-cycle issue/capture controller in front of a combinational MIPS ALU:
// decode and drive operands, capture the ALU result, emit a write-back beat with trap detection.
module alu_issue_ctrl #(
  parameter logic [7:0] STICKY_MASK = 8'hFF,
  parameter bit         TRAP_ON_OVF = 1'b1
) (
  input logic              clk,
  input logic              rst_n,
  alu_issue_ctrl_if.master bus
);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StDrive   = 2'd1;
  localparam logic [1:0] StCapture = 2'd2;

  localparam logic [3:0] CtlAnd  = 4'b0000;
  localparam logic [3:0] CtlOr   = 4'b0001;
  localparam logic [3:0] CtlAdd  = 4'b0010;
  localparam logic [3:0] CtlMult = 4'b0100;
  localparam logic [3:0] CtlDiv  = 4'b0101;
  localparam logic [3:0] CtlSub  = 4'b0110;
  localparam logic [3:0] CtlSlt  = 4'b0111;
  localparam logic [3:0] CtlNor  = 4'b1100;

  logic [1:0]  state_q, state_d;
  logic        ready_q;
  logic [3:0]  ctl_q;
  logic [31:0] op1_q, op2_q;
  logic        ill_q, ovf_chk_q, div_q, no_wr_q;
  logic [4:0]  rd_q;
  logic        wb_valid_q, wb_we_q, wb_zero_q, exc_valid_q;
  logic [4:0]  wb_idx_q;
  logic [31:0] wb_data_q;
  logic [1:0]  exc_cause_q;
  logic [7:0]  sticky_q, sticky_d;

  logic [3:0]  dec_ctl;
  logic [31:0] dec_op2, imm_sext, imm_zext;
  logic        dec_ill, dec_ovf_chk, dec_div, dec_no_wr;
  logic        accept, capture;
  logic        trap_div, trap_ovf, trap;
  logic [1:0]  cause;

  assign imm_sext = {{16{bus.imm[15]}}, bus.imm};
  assign imm_zext = {16'h0000, bus.imm};

  always_comb begin
    dec_ctl     = CtlAdd;
    dec_op2     = bus.rt_val;
    dec_ill     = 1'b0;
    dec_ovf_chk = 1'b0;
    dec_div     = 1'b0;
    dec_no_wr   = 1'b0;
    if (bus.opcode == 6'h00) begin
      case (bus.funct)
        6'h20: dec_ovf_chk = 1'b1;
        6'h21: dec_ctl = CtlAdd;
        6'h22: begin
          dec_ctl     = CtlSub;
          dec_ovf_chk = 1'b1;
        end
        6'h23: dec_ctl = CtlSub;
        6'h24: dec_ctl = CtlAnd;
        6'h25: dec_ctl = CtlOr;
        6'h27: dec_ctl = CtlNor;
        6'h2A: dec_ctl = CtlSlt;
        6'h18: dec_ctl = CtlMult;
        6'h1A: begin
          dec_ctl = CtlDiv;
          dec_div = 1'b1;
        end
        default: dec_ill = 1'b1;
      endcase
    end else begin
      case (bus.opcode)
        6'h08: begin
          dec_op2     = imm_sext;
          dec_ovf_chk = 1'b1;
        end
        6'h09, 6'h23: dec_op2 = imm_sext;
        6'h2B: begin
          dec_op2   = imm_sext;
          dec_no_wr = 1'b1;
        end
        6'h0A: begin
          dec_ctl = CtlSlt;
          dec_op2 = imm_sext;
        end
        6'h0C: begin
          dec_ctl = CtlAnd;
          dec_op2 = imm_zext;
        end
        6'h0D: begin
          dec_ctl = CtlOr;
          dec_op2 = imm_zext;
        end
        6'h04, 6'h05: begin
          dec_ctl   = CtlSub;
          dec_no_wr = 1'b1;
        end
        default: dec_ill = 1'b1;
      endcase
    end
  end

  assign accept  = (state_q == StIdle) && ready_q && bus.issue_valid;
  assign capture = (state_q == StDrive);

  // Trap priority: illegal over divide-by-zero over signed overflow.
  assign trap_div = div_q && bus.ALU_status[2];
  assign trap_ovf = TRAP_ON_OVF && ovf_chk_q && bus.ALU_status[5];
  assign trap     = ill_q || trap_div || trap_ovf;
  assign cause    = ill_q ? 2'b11 : trap_div ? 2'b10 : trap_ovf ? 2'b01 : 2'b00;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:    if (accept) state_d = StDrive;
      StDrive:   state_d = StCapture;
      StCapture: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // A clear coinciding with a capture keeps only the newly captured bits.
  always_comb begin
    sticky_d = bus.sticky_clr ? 8'h00 : sticky_q;
    if (capture && !ill_q) sticky_d = sticky_d | (bus.ALU_status & STICKY_MASK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      ready_q     <= 1'b1;
      ctl_q       <= 4'b0000;
      op1_q       <= 32'h0;
      op2_q       <= 32'h0;
      ill_q       <= 1'b0;
      ovf_chk_q   <= 1'b0;
      div_q       <= 1'b0;
      no_wr_q     <= 1'b0;
      rd_q        <= 5'd0;
      wb_valid_q  <= 1'b0;
      wb_we_q     <= 1'b0;
      wb_idx_q    <= 5'd0;
      wb_data_q   <= 32'h0;
      wb_zero_q   <= 1'b0;
      exc_valid_q <= 1'b0;
      exc_cause_q <= 2'b00;
      sticky_q    <= 8'h00;
    end else begin
      state_q     <= state_d;
      ready_q     <= (state_d == StIdle);
      wb_valid_q  <= capture;
      wb_we_q     <= capture && !trap && !no_wr_q;
      exc_valid_q <= capture && trap;
      sticky_q    <= sticky_d;
      if (accept) begin
        ctl_q     <= dec_ill ? CtlAdd : dec_ctl;
        op1_q     <= dec_ill ? 32'h0 : bus.rs_val;
        op2_q     <= dec_ill ? 32'h0 : dec_op2;
        ill_q     <= dec_ill;
        ovf_chk_q <= dec_ovf_chk;
        div_q     <= dec_div;
        no_wr_q   <= dec_no_wr;
        rd_q      <= bus.rd_idx;
      end
      if (capture) begin
        wb_data_q   <= bus.ALU_result;
        wb_idx_q    <= rd_q;
        wb_zero_q   <= bus.ALU_status[7];
        exc_cause_q <= cause;
      end
    end
  end

  assign bus.issue_ready   = ready_q;
  assign bus.ALU_control   = ctl_q;
  assign bus.ALU_op_1      = op1_q;
  assign bus.ALU_op_2      = op2_q;
  assign bus.wb_valid      = wb_valid_q;
  assign bus.wb_we         = wb_we_q;
  assign bus.wb_idx        = wb_idx_q;
  assign bus.wb_data       = wb_data_q;
  assign bus.wb_zero       = wb_zero_q;
  assign bus.exc_valid     = exc_valid_q;
  assign bus.exc_cause     = exc_cause_q;
  assign bus.sticky_status = sticky_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Randomized bench for alu_issue_ctrl: a behavioural ALU answers the DUT, and an
// instruction-level reference model predicts decode, write-back, traps and sticky status.
module tb_alu_issue_ctrl;

  localparam logic [7:0] Mask = 8'hFF;
  localparam longint SMax = 64'sd2147483647;
  localparam longint SMin = -64'sd2147483648;

  typedef enum int {
    KAdd, KAddu, KSub, KSubu, KAnd, KOr, KNor, KSlt, KMult, KDiv,
    KAddi, KAddiu, KLw, KSw, KSlti, KAndi, KOri, KBeq, KBne, KIll
  } kind_e;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [7:0] sticky_m;

  always #5 clk = ~clk;

  alu_issue_ctrl_if bus ();

  alu_issue_ctrl #(
    .STICKY_MASK(Mask),
    .TRAP_ON_OVF(1'b1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Behavioural ALU answering the DUT's drive.
  logic signed [63:0] alu_a, alu_b, alu_full;
  logic [7:0] alu_st;
  always_comb begin
    alu_a    = {{32{bus.ALU_op_1[31]}}, bus.ALU_op_1};
    alu_b    = {{32{bus.ALU_op_2[31]}}, bus.ALU_op_2};
    alu_full = '0;
    alu_st   = '0;
    case (bus.ALU_control)
      4'b0010: alu_full = alu_a + alu_b;
      4'b0110: alu_full = alu_a - alu_b;
      4'b0000: alu_full = alu_a & alu_b;
      4'b0001: alu_full = alu_a | alu_b;
      4'b1100: alu_full = ~(alu_a | alu_b);
      4'b0111: alu_full = (alu_a < alu_b) ? 64'sd1 : 64'sd0;
      4'b0100: alu_full = alu_a * alu_b;
      4'b0101: begin
        alu_full  = (alu_b == 64'sd0) ? 64'sd0 : alu_a / alu_b;
        alu_st[2] = (alu_b == 64'sd0);
      end
      default: alu_full = '0;
    endcase
    alu_st[7] = (alu_full[31:0] == 32'h0);
    alu_st[6] = (bus.ALU_control == 4'b0100) && (alu_full[63:32] != {32{alu_full[31]}});
    alu_st[5] = ((bus.ALU_control == 4'b0010) || (bus.ALU_control == 4'b0110)) &&
                (alu_full[63:32] != {32{alu_full[31]}});
    alu_st[4] = alu_full[31];
    bus.ALU_result = alu_full[31:0];
    bus.ALU_status = alu_st;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [11:0] encode(input kind_e k);
    case (k)
      KAdd:    return {6'h00, 6'h20};
      KAddu:   return {6'h00, 6'h21};
      KSub:    return {6'h00, 6'h22};
      KSubu:   return {6'h00, 6'h23};
      KAnd:    return {6'h00, 6'h24};
      KOr:     return {6'h00, 6'h25};
      KNor:    return {6'h00, 6'h27};
      KSlt:    return {6'h00, 6'h2A};
      KMult:   return {6'h00, 6'h18};
      KDiv:    return {6'h00, 6'h1A};
      KAddi:   return {6'h08, 6'h00};
      KAddiu:  return {6'h09, 6'h00};
      KLw:     return {6'h23, 6'h00};
      KSw:     return {6'h2B, 6'h00};
      KSlti:   return {6'h0A, 6'h00};
      KAndi:   return {6'h0C, 6'h00};
      KOri:    return {6'h0D, 6'h00};
      KBeq:    return {6'h04, 6'h00};
      KBne:    return {6'h05, 6'h00};
      default: return {6'h3F, 6'h3F};
    endcase
  endfunction

  function automatic kind_e classify(input logic [5:0] op, input logic [5:0] fn);
    logic [11:0] e;
    for (int i = 0; i < int'(KIll); i++) begin
      e = encode(kind_e'(i));
      if (e[11:6] == op && (op != 6'h00 || e[5:0] == fn)) return kind_e'(i);
    end
    return KIll;
  endfunction

  function automatic logic [3:0] exp_ctl(input kind_e k);
    case (k)
      KSub, KSubu, KBeq, KBne: return 4'b0110;
      KAnd, KAndi:             return 4'b0000;
      KOr, KOri:               return 4'b0001;
      KNor:                    return 4'b1100;
      KSlt, KSlti:             return 4'b0111;
      KMult:                   return 4'b0100;
      KDiv:                    return 4'b0101;
      default:                 return 4'b0010;
    endcase
  endfunction

  function automatic logic [31:0] exp_op2(input kind_e k, input logic [15:0] im,
                                          input logic [31:0] rt);
    if (k inside {KAddi, KAddiu, KLw, KSw, KSlti}) return 32'($signed(im));
    if (k inside {KAndi, KOri}) return {16'h0000, im};
    return rt;
  endfunction

  // Instruction semantics in 64-bit integer arithmetic.
  task automatic ref_alu(input kind_e k, input logic [31:0] a32, input logic [31:0] b32,
                         output logic [31:0] res, output logic [7:0] st);
    longint a, b, r;
    a  = longint'($signed(a32));
    b  = longint'($signed(b32));
    st = 8'h00;
    case (k)
      KSub, KSubu, KBeq, KBne: r = a - b;
      KAnd, KAndi:             r = a & b;
      KOr, KOri:               r = a | b;
      KNor:                    r = ~(a | b);
      KSlt, KSlti:             r = (a < b) ? 64'sd1 : 64'sd0;
      KMult:                   r = a * b;
      KDiv:                    r = (b == 64'sd0) ? 64'sd0 : a / b;
      default:                 r = a + b;
    endcase
    res   = r[31:0];
    st[7] = (res == 32'h0);
    st[6] = (k == KMult) && (r > SMax || r < SMin);
    st[5] = (k inside {KAdd, KAddu, KAddi, KAddiu, KLw, KSw, KSub, KSubu, KBeq, KBne}) &&
            (r > SMax || r < SMin);
    st[4] = res[31];
    st[2] = (k == KDiv) && (b == 64'sd0);
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic [15:0] im,
                           input logic [4:0] rd, input logic [31:0] rs, input logic [31:0] rt,
                           input bit clr_a, input bit clr_b, input bit clr_c, input bit hold);
    kind_e k;
    bit ill, trap, we;
    logic [31:0] b, r;
    logic [7:0] st;
    logic [1:0] cause;
    k   = classify(op, fn);
    ill = (k == KIll);
    b   = ill ? 32'h0 : exp_op2(k, im, rt);
    ref_alu(k, ill ? 32'h0 : rs, b, r, st);
    cause = ill ? 2'b11 :
            (k == KDiv && st[2]) ? 2'b10 :
            (k inside {KAdd, KSub, KAddi} && st[5]) ? 2'b01 : 2'b00;
    trap = (cause != 2'b00);
    we   = !trap && !(k inside {KSw, KBeq, KBne});

    check("ready_idle", 32'(bus.issue_ready), 32'd1);
    bus.issue_valid = 1'b1;
    bus.opcode = op; bus.funct = fn; bus.imm = im; bus.rd_idx = rd;
    bus.rs_val = rs; bus.rt_val = rt; bus.sticky_clr = clr_a;
    @(posedge clk);
    @(negedge clk);
    if (clr_a) sticky_m = 8'h00;
    check("ready_drive", 32'(bus.issue_ready), 32'd0);
    check("alu_control", 32'(bus.ALU_control), 32'(exp_ctl(k)));
    check("alu_op_1", bus.ALU_op_1, ill ? 32'h0 : rs);
    check("alu_op_2", bus.ALU_op_2, b);
    check("wb_valid_drive", 32'(bus.wb_valid), 32'd0);
    bus.issue_valid = hold;
    if (hold) begin
      bus.opcode = 6'($urandom); bus.funct = 6'($urandom); bus.imm = 16'($urandom);
      bus.rd_idx = 5'($urandom); bus.rs_val = $urandom; bus.rt_val = $urandom;
    end
    bus.sticky_clr = clr_b;
    @(posedge clk);
    @(negedge clk);
    sticky_m = (clr_b ? 8'h00 : sticky_m) | (ill ? 8'h00 : (st & Mask));
    check("ready_capture", 32'(bus.issue_ready), 32'd0);
    check("wb_valid", 32'(bus.wb_valid), 32'd1);
    check("wb_data", bus.wb_data, r);
    check("wb_idx", 32'(bus.wb_idx), 32'(rd));
    check("wb_zero", 32'(bus.wb_zero), 32'(st[7]));
    check("wb_we", 32'(bus.wb_we), 32'(we));
    check("exc_valid", 32'(bus.exc_valid), 32'(trap));
    if (trap) check("exc_cause", 32'(bus.exc_cause), 32'(cause));
    check("sticky_capture", 32'(bus.sticky_status), 32'(sticky_m));
    bus.sticky_clr = clr_c;
    @(posedge clk);
    @(negedge clk);
    if (clr_c) sticky_m = 8'h00;
    check("wb_valid_after", 32'(bus.wb_valid), 32'd0);
    check("exc_valid_after", 32'(bus.exc_valid), 32'd0);
    check("wb_idx_hold", 32'(bus.wb_idx), 32'(rd));
    check("sticky_idle", 32'(bus.sticky_status), 32'(sticky_m));
    bus.sticky_clr = 1'b0;
  endtask

  initial begin
    kind_e k;
    logic [11:0] e;
    logic [5:0] op, fn;
    logic [15:0] im;
    logic [31:0] rs, rt;

    rst_n = 1'b0;
    bus.issue_valid = 1'b0; bus.opcode = '0; bus.funct = '0; bus.imm = '0;
    bus.rd_idx = '0; bus.rs_val = '0; bus.rt_val = '0; bus.sticky_clr = 1'b0;
    sticky_m = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(bus.issue_ready), 32'd1);
    check("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
    check("rst_exc_valid", 32'(bus.exc_valid), 32'd0);
    check("rst_alu_control", 32'(bus.ALU_control), 32'd0);
    check("rst_wb_data", bus.wb_data, 32'd0);
    check("rst_sticky", 32'(bus.sticky_status), 32'd0);
    rst_n = 1'b1;

    // Directed cases.
    run_instr(6'h00, 6'h20, 16'h0000, 5'd3, 32'd5, 32'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    run_instr(6'h08, 6'h00, 16'h0001, 5'd4, 32'h7FFF_FFFF, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_instr(6'h09, 6'h00, 16'h0001, 5'd4, 32'h7FFF_FFFF, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_instr(6'h00, 6'h1A, 16'h0000, 5'd5, 32'd10, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("sticky_div0", 32'(bus.sticky_status[2]), 32'd1);
    run_instr(6'h00, 6'h24, 16'h0000, 5'd6, 32'hF0, 32'h0F, 1'b0, 1'b1, 1'b0, 1'b0);
    check("sticky_clr_capture", 32'(bus.sticky_status), 32'h80);
    run_instr(6'h0C, 6'h00, 16'h8001, 5'd7, 32'hFFFF_1234, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_instr(6'h04, 6'h00, 16'h0010, 5'd8, 32'd9, 32'd9, 1'b0, 1'b0, 1'b0, 1'b0);
    run_instr(6'h3F, 6'h00, 16'h0000, 5'd9, 32'd1, 32'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    run_instr(6'h00, 6'h25, 16'h0000, 5'd1, 32'h1, 32'h2, 1'b0, 1'b0, 1'b0, 1'b1);
    run_instr(6'h00, 6'h22, 16'h0000, 5'd2, 32'h8000_0000, 32'h1, 1'b0, 1'b0, 1'b1, 1'b1);

    // Reset asserted while an instruction sits in DRIVE.
    bus.issue_valid = 1'b1; bus.opcode = 6'h00; bus.funct = 6'h20;
    bus.rs_val = 32'd1; bus.rt_val = 32'd2; bus.rd_idx = 5'd12;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 32'(bus.issue_ready), 32'd1);
    check("mid_rst_alu_op_1", bus.ALU_op_1, 32'd0);
    check("mid_rst_wb_idx", 32'(bus.wb_idx), 32'd0);
    check("mid_rst_sticky", 32'(bus.sticky_status), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.issue_valid = 1'b0;
    sticky_m = 8'h00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_wb_valid", 32'(bus.wb_valid), 32'd0);
      check("post_rst_exc_valid", 32'(bus.exc_valid), 32'd0);
    end

    // Randomized instruction stream against the reference model.
    for (int n = 0; n < 300; n++) begin
      k  = kind_e'($urandom_range(0, 19));
      e  = encode(k);
      op = e[11:6];
      fn = (op == 6'h00) ? e[5:0] : 6'($urandom);
      if (k == KIll) begin
        op = ($urandom_range(0, 1) == 1) ? 6'h3F : 6'h00;
        fn = 6'h3F;
      end
      im = 16'($urandom);
      case ($urandom_range(0, 3))
        0: begin rs = $urandom; rt = $urandom; end
        1: begin rs = $urandom_range(0, 20); rt = $urandom_range(0, 20); end
        2: begin
          rs = ($urandom_range(0, 1) == 1) ? 32'h7FFF_FFFF : 32'h8000_0000;
          rt = ($urandom_range(0, 1) == 1) ? 32'h0000_0001 : 32'hFFFF_FFFF;
          im = ($urandom_range(0, 1) == 1) ? 16'h0001 : 16'hFFFF;
        end
        default: begin rs = $urandom; rt = 32'h0; end
      endcase
      run_instr(op, fn, im, 5'($urandom), rs, rt, ($urandom_range(0, 5) == 0),
                ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
                ($urandom_range(0, 1) == 1));
    end
    bus.issue_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
